// File: rtl/ssram_pkg.sv
// Shared types and constants for the synchronous-SRAM controller.
package ssram_pkg;

    localparam int unsigned BurstLen       = 4;
    localparam int unsigned DefReadLatency = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdCmd,
        StRdWait,
        StBurst,
        StTurn
    } state_e;

endpackage

// File: rtl/ssram_rdpipe.sv
// Read-latency valid pipe: one strobe per issued read beat, delayed to its capture edge.
module ssram_rdpipe #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic issue_i,
    output logic cap_o,
    output logic valid_o,
    output logic busy_o
);

    localparam logic [DEPTH-1:0] TopBit = {1'b1, {(DEPTH-1){1'b0}}};

    logic [DEPTH-1:0] pipe_q, pipe_d;
    logic [DEPTH:0]   taps;

    // taps[0] is the live issue strobe, taps[k] is that strobe k clocks later
    assign taps = {pipe_q, issue_i};

    always_comb begin
        pipe_d = clr_i ? '0 : taps[DEPTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // cap_o fires on the edge that loads readdata; valid_o flags the cycle readdata is valid
    assign cap_o   = taps[DEPTH-1];
    assign valid_o = taps[DEPTH];
    assign busy_o  = |(pipe_q & ~TopBit);

endmodule

// File: rtl/ssram_ctrl.sv
// Single-word / 4-beat burst controller for a pair of pipelined synchronous SRAMs.
module ssram_ctrl
    import ssram_pkg::*;
#(
    parameter int unsigned READ_LATENCY = DefReadLatency,
    parameter int unsigned BURST_LEN    = BurstLen
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read,
    input  logic        write,
    input  logic        burst,
    input  logic [26:0] address,
    input  logic [31:0] writedata,
    input  logic [3:0]  be,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readvalid,
    output logic [26:0] ssram_addr,
    output logic [31:0] ssram_data_out,
    output logic        ssram_data_oe,
    input  logic [31:0] ssram_data_in,
    output logic [3:0]  ssram_be_n,
    output logic        ssram_oe_n,
    output logic        ssram_we_n,
    output logic        ssram_adsc_n,
    output logic        ssram_adsp_n,
    output logic        ssram_adv_n,
    output logic        ssram0_ce_n,
    output logic        ssram1_ce_n
);

    state_e      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [26:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        burst_q, burst_d;
    logic [31:0] readdata_q, readdata_d;

    logic issue, pipe_clr, cap, rd_valid, rd_busy, ce_act;

    ssram_rdpipe #(
        .DEPTH (READ_LATENCY)
    ) u_rdpipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (pipe_clr),
        .issue_i (issue),
        .cap_o   (cap),
        .valid_o (rd_valid),
        .busy_o  (rd_busy)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        burst_d       = burst_q;
        readdata_d    = cap ? ssram_data_in : readdata_q;
        issue         = 1'b0;
        ce_act        = 1'b0;
        pipe_clr      = 1'b0;
        waitrequest   = 1'b1;
        ssram_data_oe = 1'b0;
        ssram_be_n    = 4'b1111;
        ssram_oe_n    = 1'b1;
        ssram_we_n    = 1'b1;
        ssram_adsc_n  = 1'b1;
        ssram_adv_n   = 1'b1;

        unique case (state_q)
            StIdle: begin
                waitrequest = 1'b0;
                pipe_clr    = 1'b1;
                if (read || write) begin
                    addr_d  = address;
                    wdata_d = writedata;
                    be_d    = be;
                    burst_d = burst;
                    // write wins when both are requested together
                    state_d = write ? StWrite : StRdCmd;
                end
            end
            StWrite: begin
                ssram_adsc_n  = 1'b0;
                ssram_we_n    = 1'b0;
                ce_act        = 1'b1;
                ssram_data_oe = 1'b1;
                ssram_be_n    = ~be_q;
                state_d       = StIdle;
            end
            StRdCmd: begin
                ssram_adsc_n = 1'b0;
                ce_act       = 1'b1;
                issue        = 1'b1;
                beat_d       = 2'd1;
                state_d      = burst_q ? StBurst : StRdWait;
            end
            StBurst: begin
                // the SRAM's own linear counter walks addr[3:2] with wrap
                ssram_adv_n = 1'b0;
                ssram_oe_n  = 1'b0;
                issue       = 1'b1;
                if (beat_q == 2'(BURST_LEN - 1)) begin
                    state_d = StRdWait;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            StRdWait: begin
                ssram_oe_n = 1'b0;
                if (rd_valid && !rd_busy) begin
                    state_d = StTurn;
                end
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            burst_q    <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            burst_q    <= burst_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata       = readdata_q;
    assign readvalid      = rd_valid;
    assign ssram_addr     = addr_q;
    assign ssram_data_out = wdata_q;
    assign ssram_adsp_n   = 1'b1;
    assign ssram0_ce_n    = ~(ce_act & ~addr_q[22]);
    assign ssram1_ce_n    = ~(ce_act & addr_q[22]);

endmodule

// File: tb/tb_ssram_ctrl.sv
// Self-checking bench for ssram_ctrl: vector table plus SRAM model and read scoreboard.
module tb_ssram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read = 1'b0, write = 1'b0, burst = 1'b0;
    logic [26:0] address = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  be = '0;
    logic        waitrequest, readvalid;
    logic [31:0] readdata;
    logic [26:0] ssram_addr;
    logic [31:0] ssram_data_out, ssram_data_in;
    logic        ssram_data_oe;
    logic [3:0]  ssram_be_n;
    logic        ssram_oe_n, ssram_we_n, ssram_adsc_n, ssram_adsp_n, ssram_adv_n;
    logic        ssram0_ce_n, ssram1_ce_n;

    ssram_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read           (read),
        .write          (write),
        .burst          (burst),
        .address        (address),
        .writedata      (writedata),
        .be             (be),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .readvalid      (readvalid),
        .ssram_addr     (ssram_addr),
        .ssram_data_out (ssram_data_out),
        .ssram_data_oe  (ssram_data_oe),
        .ssram_data_in  (ssram_data_in),
        .ssram_be_n     (ssram_be_n),
        .ssram_oe_n     (ssram_oe_n),
        .ssram_we_n     (ssram_we_n),
        .ssram_adsc_n   (ssram_adsc_n),
        .ssram_adsp_n   (ssram_adsp_n),
        .ssram_adv_n    (ssram_adv_n),
        .ssram0_ce_n    (ssram0_ce_n),
        .ssram1_ce_n    (ssram1_ce_n)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0, n_pass = 0, viol = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 24) ? 32'h1234_5678 : 32'hA000_0000 + 32'(i) * 32'h111;
    endfunction

    // pipelined SSRAM model (read latency 2: data on the pins the cycle after the command)
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [26:0] m_addr = '0;
    logic        m_chip = 1'b0;
    logic [31:0] rd_q = '0;
    assign ssram_data_in = rd_q;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!ssram_adsc_n) begin
            m_addr = ssram_addr;
            m_chip = !ssram1_ce_n;
            if (!ssram_we_n) begin
                for (int b = 0; b < 4; b++)
                    if (!ssram_be_n[b]) mem[{m_chip, m_addr[5:2]}][b*8 +: 8] = ssram_data_out[b*8 +: 8];
            end else begin
                rd_q <= mem[{m_chip, m_addr[5:2]}];
            end
        end else if (!ssram_adv_n) begin
            m_addr[3:2] = m_addr[3:2] + 2'd1;
            rd_q <= mem[{m_chip, m_addr[5:2]}];
        end
    end

    // read scoreboard
    typedef struct { logic [31:0] data; int unsigned cyc; } exp_t;
    exp_t sbq[$];

    always @(negedge clk) begin
        if (readvalid) begin
            if (sbq.size() == 0) begin
                check("unexpected readvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("readdata", readdata, e.data);
                check("readvalid cycle", cyc, e.cyc);
            end
        end
    end

    // bus-protocol monitor: no drive fight, one-cycle turnaround, single chip select
    logic prev_oe_n = 1'b1;
    always @(negedge clk) begin
        if (ssram_data_oe && (!ssram_oe_n || !prev_oe_n)) viol++;
        if (!ssram0_ce_n && !ssram1_ce_n) viol++;
        if (!ssram_adsp_n) viol++;
        prev_oe_n <= ssram_oe_n;
    end

    typedef struct {
        logic        rd, wr, bst;
        logic [26:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chip1;
        logic [3:0]  be_n;
        int unsigned beats;
        int unsigned idle_at;
    } vec_t;

    vec_t vecs[9];

    task automatic idle_controls(input string name);
        check({name, " controls"},
              {25'd0, ssram_oe_n, ssram_we_n, ssram_adsc_n, ssram_adsp_n, ssram_adv_n,
               ssram0_ce_n, ssram1_ce_n}, 32'h7F);
        check({name, " be_n"}, ssram_be_n, 4'hF);
        check({name, " data_oe"}, ssram_data_oe, 1'b0);
        check({name, " waitrequest"}, waitrequest, 1'b0);
        check({name, " readvalid"}, readvalid, 1'b0);
        check({name, " ssram_addr"}, ssram_addr, 27'd0);
        check({name, " data_out"}, ssram_data_out, 32'd0);
        check({name, " readdata"}, readdata, 32'd0);
    endtask

    // called at a negedge with the DUT idle; returns at the negedge it is idle again
    task automatic run_vec(input vec_t v);
        int unsigned n, adv_low;
        bit done;
        logic [4:0] idx;
        logic [1:0] w;
        check("waitrequest before request", waitrequest, 1'b0);
        read = v.rd; write = v.wr; burst = v.bst;
        address = v.addr; writedata = v.wdata; be = v.be;
        n = cyc;
        idx = {v.addr[22], v.addr[5:2]};
        if (v.wr) begin
            for (int b = 0; b < 4; b++)
                if (v.be[b]) ref_mem[idx][b*8 +: 8] = v.wdata[b*8 +: 8];
        end else begin
            for (int i = 0; i < int'(v.beats); i++) begin
                w = v.addr[3:2] + 2'(i);
                sbq.push_back('{data: ref_mem[{v.addr[22], v.addr[5:4], w}], cyc: n + 3 + i});
            end
        end
        @(negedge clk);
        // scramble the request inputs: the latched copy must be used
        read = 1'b0; write = 1'b0; burst = 1'b0;
        address = 27'($urandom); writedata = $urandom; be = 4'($urandom);
        check("waitrequest busy", waitrequest, 1'b1);
        check("adsc_n command", ssram_adsc_n, 1'b0);
        check("ssram_addr", ssram_addr, v.addr);
        check("chip select", {ssram1_ce_n, ssram0_ce_n}, v.chip1 ? 2'b01 : 2'b10);
        check("we_n", ssram_we_n, !v.wr);
        check("be_n", ssram_be_n, v.be_n);
        check("data_oe", ssram_data_oe, v.wr);
        if (v.wr) check("data_out", ssram_data_out, v.wdata);
        adv_low = 0;
        done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (!ssram_adv_n) adv_low++;
            if (!v.wr && cyc == n + v.idle_at - 1)
                check("turn cycle", {ssram_oe_n, ssram_data_oe, ssram1_ce_n, ssram0_ce_n,
                      waitrequest}, 5'b10111);
            if (!waitrequest) done = 1'b1;
        end
        if (!done) check("idle timeout", 32'd0, 32'd1);
        else check("idle cycle", cyc - n, v.idle_at);
        check("adv_n low cycles", adv_low, (v.beats == 0) ? 0 : v.beats - 1);
        check("beats outstanding", sbq.size(), 0);
    endtask

    initial begin
        vecs[0] = '{0, 1, 0, 27'h0000010, 32'hDEAD_BEEF, 4'b0011, 0, 4'b1100, 0, 2};
        vecs[1] = '{1, 0, 0, 27'h0400020, 32'h0,         4'b0000, 1, 4'b1111, 1, 5};
        vecs[2] = '{1, 0, 1, 27'h0000008, 32'h0,         4'b0000, 0, 4'b1111, 4, 8};
        vecs[3] = '{1, 0, 0, 27'h0000010, 32'h0,         4'b0000, 0, 4'b1111, 1, 5};
        vecs[4] = '{1, 1, 1, 27'h0400004, 32'hCAFE_F00D, 4'b1111, 1, 4'b0000, 0, 2};
        vecs[5] = '{1, 0, 0, 27'h0400004, 32'h0,         4'b0000, 1, 4'b1111, 1, 5};
        vecs[6] = '{0, 1, 0, 27'h000000C, 32'h1122_3344, 4'b1000, 0, 4'b0111, 0, 2};
        vecs[7] = '{1, 0, 1, 27'h040000C, 32'h0,         4'b0000, 1, 4'b1111, 4, 8};
        vecs[8] = '{1, 0, 1, 27'h0000000, 32'h0,         4'b0000, 0, 4'b1111, 4, 8};

        repeat (2) @(negedge clk);
        idle_controls("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset during the second beat of a burst
        begin
            vec_t vb;
            vb = '{1, 0, 1, 27'h0000004, 32'h0, 4'b0000, 0, 4'b1111, 4, 8};
            read = 1'b1; burst = 1'b1; address = vb.addr;
            for (int i = 0; i < 4; i++)
                sbq.push_back('{data: ref_mem[5'(1 + i) & 5'h3], cyc: cyc + 3 + i});
            @(negedge clk);
            read = 1'b0; burst = 1'b0;
            repeat (3) @(negedge clk);
            #2 rst_n = 1'b0;
            #1 idle_controls("mid-burst reset");
            check("beats left at reset", sbq.size(), 2);
            sbq.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            run_vec(vecs[1]);
        end

        repeat (4) @(negedge clk);
        check("protocol violations", viol, 0);
        check("scoreboard empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

endmodule
